// File: rtl/hps_pkg.sv
// Shared constants and state encoding for the HPS PS/2 device-side transmitter.
package hps_pkg;

   localparam int PS2_FRAME_BITS = 11;

   typedef enum logic [3:0] {
      PS2_ST_IDLE   = 4'd0,
      PS2_ST_D0     = 4'd1,
      PS2_ST_D1     = 4'd2,
      PS2_ST_D2     = 4'd3,
      PS2_ST_D3     = 4'd4,
      PS2_ST_D4     = 4'd5,
      PS2_ST_D5     = 4'd6,
      PS2_ST_D6     = 4'd7,
      PS2_ST_D7     = 4'd8,
      PS2_ST_PARITY = 4'd9,
      PS2_ST_STOP   = 4'd10,
      PS2_ST_LAST   = 4'd11
   } ps2_state_t;

endpackage

// File: rtl/hps_ps2_chan.sv
// One PS/2 transmit channel: byte FIFO plus 11-bit frame serialiser.
// Host-inhibit abort handling is compiled in with HPS_PS2_INHIBIT_EN.
module hps_ps2_chan
   import hps_pkg::*;
#(
   parameter int FIFO_BITS = 3
)
(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       tick,
   input  logic       clk_ps2,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       ovf_clr,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       fifo_full,
   output logic       overflow,
   output logic       busy
`ifdef HPS_PS2_INHIBIT_EN
   ,
   input  logic       ps2_clk_in
`endif
);

   localparam int DEPTH = 1 << FIFO_BITS;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_BITS:0] wptr, rptr;
   ps2_state_t         state, state_nxt;
   logic [7:0]         shreg, shreg_nxt;
   logic               parity, parity_nxt;
   logic               data_q, data_nxt;
   logic               ovf_q;
   logic               pop, full, empty, wr_ok, start_ok, abort;

   assign full  = (wptr ^ rptr) == {1'b1, {FIFO_BITS{1'b0}}};
   assign empty = wptr == rptr;
   // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
   assign wr_ok = wr_en & (~full | pop);

`ifdef HPS_PS2_INHIBIT_EN
   logic inh_now, inh_q;

   assign inh_now  = clk_ps2 & ~ps2_clk_in & (state >= PS2_ST_D0) & (state <= PS2_ST_STOP);
   assign abort    = inh_now & inh_q;
   assign start_ok = ~empty & ps2_clk_in;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) inh_q <= 1'b0;
      else       inh_q <= inh_now;
   end
`else
   assign abort    = 1'b0;
   assign start_ok = ~empty;
`endif

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= PS2_ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = PS2_ST_IDLE;
      end else if (tick) begin
         case (state)
            PS2_ST_IDLE: if (start_ok) state_nxt = PS2_ST_D0;
            default:     state_nxt = (state < PS2_ST_LAST) ? ps2_state_t'(state + 4'd1)
                                                           : PS2_ST_IDLE;
         endcase
      end
   end

   // Line value and shifter update take effect on the edge after the tick.
   always_comb begin
      data_nxt   = data_q;
      shreg_nxt  = shreg;
      parity_nxt = parity;
      pop        = 1'b0;
      if (abort) begin
         data_nxt = 1'b1;
      end else if (tick) begin
         case (state)
            PS2_ST_IDLE: begin
               if (start_ok) begin
                  shreg_nxt  = mem[rptr[FIFO_BITS-1:0]];
                  parity_nxt = 1'b1;
                  data_nxt   = 1'b0;
               end
            end
            PS2_ST_PARITY: data_nxt = parity;
            PS2_ST_STOP: begin
               data_nxt = 1'b1;
               pop      = 1'b1;
            end
            default: begin
               if (state < PS2_ST_PARITY) begin
                  data_nxt   = shreg[0];
                  shreg_nxt  = {1'b0, shreg[7:1]};
                  parity_nxt = parity ^ shreg[0];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         data_q <= 1'b1;
         shreg  <= 8'd0;
         parity <= 1'b1;
         wptr   <= '0;
         rptr   <= '0;
         ovf_q  <= 1'b0;
      end else begin
         data_q <= data_nxt;
         shreg  <= shreg_nxt;
         parity <= parity_nxt;
         if (wr_ok) wptr <= wptr + 1'b1;
         if (pop)   rptr <= rptr + 1'b1;
         if (wr_en && !wr_ok) ovf_q <= 1'b1;
         else if (ovf_clr)    ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (wr_ok) mem[wptr[FIFO_BITS-1:0]] <= wr_data;
   end

   assign ps2_clk   = clk_ps2 | (state == PS2_ST_IDLE);
   assign ps2_data  = data_q;
   assign fifo_full = full;
   assign overflow  = ovf_q;
   assign busy      = (state != PS2_ST_IDLE) | ~empty;

endmodule

// File: rtl/hps_ps2_tx.sv
// PS/2 device-side transmitter array: shared clock divider plus CHANNELS FIFO/serialisers.
// Define HPS_PS2_INHIBIT_EN to add the ps2_clk_in host-inhibit sense port.
module hps_ps2_tx
   import hps_pkg::*;
#(
   parameter int  CHANNELS  = 2,
   parameter int  FIFO_BITS = 3,
   parameter int  PS2DIV    = 1000,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)
(
   input  logic                clk_sys,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [7:0]          wr_data,
   input  logic [CHANNELS-1:0] ovf_clr,
   output logic [CHANNELS-1:0] ps2_clk,
   output logic [CHANNELS-1:0] ps2_data,
   output logic [CHANNELS-1:0] fifo_full,
   output logic [CHANNELS-1:0] overflow,
   output logic [CHANNELS-1:0] busy
`ifdef HPS_PS2_INHIBIT_EN
   ,
   input  logic [CHANNELS-1:0] ps2_clk_in
`endif
);

   localparam int CNT_W = (PS2DIV > 0) ? $clog2(PS2DIV + 1) : 1;

   logic [CNT_W-1:0] cnt;
   logic             clk_ps2, clk_ps2_d, tick;

   // Single divider shared by every channel keeps all frames phase-aligned.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         clk_ps2   <= 1'b0;
         clk_ps2_d <= 1'b0;
      end else begin
         clk_ps2_d <= clk_ps2;
         if (cnt == CNT_W'(PS2DIV)) begin
            cnt     <= '0;
            clk_ps2 <= ~clk_ps2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign tick = clk_ps2 & ~clk_ps2_d;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      hps_ps2_chan #(
         .FIFO_BITS (FIFO_BITS)
      ) u_chan (
         .clk_sys    (clk_sys),
         .reset      (reset),
         .tick       (tick),
         .clk_ps2    (clk_ps2),
         .wr_en      (wr_en && (wr_ch == CH_W'(i))),
         .wr_data    (wr_data),
         .ovf_clr    (ovf_clr[i]),
         .ps2_clk    (ps2_clk[i]),
         .ps2_data   (ps2_data[i]),
         .fifo_full  (fifo_full[i]),
         .overflow   (overflow[i]),
         .busy       (busy[i])
`ifdef HPS_PS2_INHIBIT_EN
         ,
         .ps2_clk_in (ps2_clk_in[i])
`endif
      );
   end

endmodule

// File: tb/tb_hps_ps2_tx.sv
// Directed self-checking bench for hps_ps2_tx (2 channels, 4-deep FIFOs, PS2DIV=3).
module tb_hps_ps2_tx;
   import hps_pkg::*;

   logic       clk_sys;
   logic       reset;
   logic       wr_en;
   logic [0:0] wr_ch;
   logic [7:0] wr_data;
   logic [1:0] ovf_clr;
   logic [1:0] ps2_clk, ps2_data, fifo_full, overflow, busy;
`ifdef HPS_PS2_INHIBIT_EN
   logic [1:0] ps2_clk_in;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   hps_ps2_tx #(
      .CHANNELS  (2),
      .FIFO_BITS (2),
      .PS2DIV    (3)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_ch      (wr_ch),
      .wr_data    (wr_data),
      .ovf_clr    (ovf_clr),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .busy       (busy)
`ifdef HPS_PS2_INHIBIT_EN
      ,
      .ps2_clk_in (ps2_clk_in)
`endif
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Frame capture: sample ps2_data on each falling ps2_clk; a long high stretch drops a partial frame.
   logic [10:0] part [2];
   int          bitcnt [2];
   int          hi_run [2];
   logic        prev_clk [2];
   int          done_cyc [2];
   int          cyc = 0;
   logic [10:0] q0 [$];
   logic [10:0] q1 [$];

   always @(negedge clk_sys) begin
      cyc++;
      for (int c = 0; c < 2; c++) begin
         if (reset) begin
            bitcnt[c]   = 0;
            hi_run[c]   = 0;
            prev_clk[c] = 1'b1;
            if (c == 0) q0.delete();
            else        q1.delete();
         end else begin
            if (ps2_clk[c]) begin
               hi_run[c]++;
               if (hi_run[c] > 6) bitcnt[c] = 0;
            end else begin
               hi_run[c] = 0;
            end
            if (prev_clk[c] && !ps2_clk[c]) begin
               part[c][bitcnt[c]] = ps2_data[c];
               bitcnt[c]++;
               if (bitcnt[c] == PS2_FRAME_BITS) begin
                  if (c == 0) q0.push_back(part[c]);
                  else        q1.push_back(part[c]);
                  done_cyc[c] = cyc;
                  bitcnt[c]   = 0;
               end
            end
            prev_clk[c] = ps2_clk[c];
         end
      end
   end

   function automatic logic [10:0] frame_of(input logic [7:0] b);
      return {1'b1, ~^b, b, 1'b0};
   endfunction

   task automatic step();
      @(negedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      step();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic do_write(input int ch, input logic [7:0] b);
      step();
      wr_en   = 1'b1;
      wr_ch   = 1'(ch);
      wr_data = b;
   endtask

   task automatic applyStimulus_idle();
      step();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_checks++;
      if (ps2_data !== 2'b11) begin n_fail++; $display("[TB] FAIL reset_data: got %b expected 11", ps2_data); end
      n_checks++;
      if (ps2_clk !== 2'b11) begin n_fail++; $display("[TB] FAIL reset_clk: got %b expected 11", ps2_clk); end
      n_checks++;
      if (overflow !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ovf: got %b expected 00", overflow); end
      n_checks++;
      if (fifo_full !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_full: got %b expected 00", fifo_full); end
      n_checks++;
      if (busy !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 00", busy); end
      reset = 1'b0;
   endtask

   task automatic test_single_byte();
      int k;
      do_reset();
      do_write(0, 8'h1C);
      applyStimulus_idle();
      n_checks++;
      if (busy[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy: got %b expected 1", busy[0]); end
      k = 0;
      while (q0.size() < 1 && k < 300) begin step(); k++; end
      n_checks++;
      if (q0.size() < 1 || q0[0] !== 11'h438)
         begin n_fail++; $display("[TB] FAIL single_frame: got %h (n=%0d) expected 438", q0.size() ? q0[0] : 11'h0, q0.size()); end
      k = 0;
      while (busy[0] !== 1'b0 && k < 30) begin step(); k++; end
      n_checks++;
      if (busy[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy_drop: got %b expected 0", busy[0]); end
      n_checks++;
      if (ps2_clk[0] !== 1'b1 || ps2_data[0] !== 1'b1)
         begin n_fail++; $display("[TB] FAIL single_idle_line: got clk %b data %b expected 1 1", ps2_clk[0], ps2_data[0]); end
   endtask

   task automatic test_overflow();
      logic [10:0] exp_f [4] = '{11'h622, 11'h644, 11'h666, 11'h688};
      int k;
      do_reset();
      do_write(1, 8'h11);
      do_write(1, 8'h22);
      do_write(1, 8'h33);
      do_write(1, 8'h44);
      step();
      n_checks++;
      if (fifo_full[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_full4: got %b expected 1", fifo_full[1]); end
      n_checks++;
      if (overflow[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_early: got %b expected 0", overflow[1]); end
      wr_data = 8'h55;
      step();
      wr_en = 1'b0;
      n_checks++;
      if (overflow !== 2'b10) begin n_fail++; $display("[TB] FAIL ovf_set: got %b expected 10", overflow); end
      k = 0;
      while (q1.size() < 4 && k < 1500) begin step(); k++; end
      repeat (300) step();
      n_checks++;
      if (q1.size() != 4) begin n_fail++; $display("[TB] FAIL ovf_frame_count: got %0d expected 4", q1.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < q1.size()) begin
            n_checks++;
            if (q1[i] !== exp_f[i]) begin n_fail++; $display("[TB] FAIL ovf_frame%0d: got %h expected %h", i, q1[i], exp_f[i]); end
         end
      end
      n_checks++;
      if (overflow[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow[1]); end
      step();
      ovf_clr = 2'b10;
      step();
      ovf_clr = 2'b00;
      n_checks++;
      if (overflow[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow[1]); end
   endtask

   task automatic test_independence();
      int  k;
      logic low_seen;
      do_reset();
      do_write(0, 8'hAA);
      do_write(1, 8'h55);
      applyStimulus_idle();
      k = 0;
      while ((q0.size() < 1 || q1.size() < 1) && k < 400) begin step(); k++; end
      n_checks++;
      if (q0.size() < 1 || q0[0] !== 11'h754)
         begin n_fail++; $display("[TB] FAIL indep_ch0: got %h (n=%0d) expected 754", q0.size() ? q0[0] : 11'h0, q0.size()); end
      n_checks++;
      if (q1.size() < 1 || q1[0] !== 11'h6AA)
         begin n_fail++; $display("[TB] FAIL indep_ch1: got %h (n=%0d) expected 6aa", q1.size() ? q1[0] : 11'h0, q1.size()); end
      n_checks++;
      if (done_cyc[0] != done_cyc[1])
         begin n_fail++; $display("[TB] FAIL indep_simul: got ch0 cycle %0d ch1 cycle %0d expected equal", done_cyc[0], done_cyc[1]); end
      repeat (20) step();
      low_seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (ps2_clk[0] !== 1'b1) low_seen = 1'b1;
      end
      n_checks++;
      if (low_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL indep_clk_idle: got low %b expected 0", low_seen); end
   endtask

   task automatic test_mid_reset();
      int k;
      do_reset();
      do_write(0, 8'hF0);
      applyStimulus_idle();
      k = 0;
      while (bitcnt[0] != 5 && k < 300) begin step(); k++; end
      n_checks++;
      if (bitcnt[0] != 5) begin n_fail++; $display("[TB] FAIL midrst_reach: got bit %0d expected 5", bitcnt[0]); end
      reset = 1'b1;
      step();
      n_checks++;
      if (ps2_data[0] !== 1'b1 || ps2_clk[0] !== 1'b1 || busy[0] !== 1'b0)
         begin n_fail++; $display("[TB] FAIL midrst_idle: got data %b clk %b busy %b expected 1 1 0", ps2_data[0], ps2_clk[0], busy[0]); end
      step();
      reset = 1'b0;
      repeat (400) step();
      n_checks++;
      if (q0.size() != 0 || busy[0] !== 1'b0)
         begin n_fail++; $display("[TB] FAIL midrst_quiet: got frames %0d busy %b expected 0 0", q0.size(), busy[0]); end
   endtask

   task automatic test_write_pop_collision();
      int k;
      do_reset();
      for (int i = 0; i < 4; i++) do_write(1, 8'hA1 + 8'(i));
      applyStimulus_idle();
      n_checks++;
      if (fifo_full[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_full: got %b expected 1", fifo_full[1]); end
      k = 0;
      while (bitcnt[1] != 10 && k < 300) begin step(); k++; end
      n_checks++;
      if (bitcnt[1] != 10) begin n_fail++; $display("[TB] FAIL coll_reach: got bit %0d expected 10", bitcnt[1]); end
      repeat (3) step();
      do_write(1, 8'hA5);
      applyStimulus_idle();
      n_checks++;
      if (overflow[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL coll_ovf: got %b expected 0", overflow[1]); end
      n_checks++;
      if (fifo_full[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_refull: got %b expected 1", fifo_full[1]); end
      k = 0;
      while (q1.size() < 5 && k < 1500) begin step(); k++; end
      n_checks++;
      if (q1.size() != 5) begin n_fail++; $display("[TB] FAIL coll_count: got %0d expected 5", q1.size()); end
      for (int i = 0; i < 5; i++) begin
         if (i < q1.size()) begin
            n_checks++;
            if (q1[i] !== frame_of(8'hA1 + 8'(i)))
               begin n_fail++; $display("[TB] FAIL coll_frame%0d: got %h expected %h", i, q1[i], frame_of(8'hA1 + 8'(i))); end
         end
      end
   endtask

`ifdef HPS_PS2_INHIBIT_EN
   task automatic test_inhibit();
      int k;
      do_reset();
      do_write(0, 8'hF0);
      applyStimulus_idle();
      k = 0;
      while (bitcnt[0] != 5 && k < 300) begin step(); k++; end
      ps2_clk_in[0] = 1'b0;
      repeat (9) step();
      n_checks++;
      if (ps2_data[0] !== 1'b1 || ps2_clk[0] !== 1'b1 || busy[0] !== 1'b1)
         begin n_fail++; $display("[TB] FAIL inh_abort: got data %b clk %b busy %b expected 1 1 1", ps2_data[0], ps2_clk[0], busy[0]); end
      ps2_clk_in[0] = 1'b1;
      k = 0;
      while (q0.size() < 1 && k < 400) begin step(); k++; end
      repeat (300) step();
      n_checks++;
      if (q0.size() != 1 || q0[0] !== 11'h7E0)
         begin n_fail++; $display("[TB] FAIL inh_resend: got %h (n=%0d) expected 7e0 once", q0.size() ? q0[0] : 11'h0, q0.size()); end
   endtask
`endif

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_ch   = 1'b0;
      wr_data = 8'h00;
      ovf_clr = 2'b00;
`ifdef HPS_PS2_INHIBIT_EN
      ps2_clk_in = 2'b11;
`endif
      test_reset();
      test_single_byte();
      test_overflow();
      test_independence();
      test_mid_reset();
      test_write_pop_collision();
`ifdef HPS_PS2_INHIBIT_EN
      test_inhibit();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
